// File: rtl/platform_pio_pkg.sv
// Shared definitions for the platform PIO blocks: register offsets, edge-select codes, clog2.
package platform_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        PIO_EDGE_RISE = 2'd0,
        PIO_EDGE_FALL = 2'd1,
        PIO_EDGE_ANY  = 2'd2
    } pio_edge_e;

    // Bits needed to hold values 0..v-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/platform_pio_debounce.sv
// Single-bit debounce filter: the output follows the synchronised input only after it has
// held one value for DEBOUNCE_CYCLES+1 consecutive samples.
module platform_pio_debounce
    import platform_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic filtered_o
);

    localparam int unsigned CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          cand_q, cand_d;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cand_d = sync_i;
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync_i != cand_q) begin
            cnt_d = '0;
        end else if (cand_q != filt_q && cnt_q == CNT_LAST) begin
            // Counter reaches DEBOUNCE_CYCLES on this sample: commit and restart.
            filt_d = cand_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cand_q <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filtered_o = filt_q;

endmodule

// File: rtl/platform_pio_keys_in.sv
// Avalon-MM input PIO: synchroniser, optional debounce (PIO_DEBOUNCE_EN), armed edge capture,
// W1C edge register, interrupt mask and zero-latency read mux.
module platform_pio_keys_in
    import platform_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned DEB_LAT = DEBOUNCE_CYCLES;
`else
    localparam int unsigned DEB_LAT = 0;
`endif
    // Filtered settles SYNC_STAGES+DEB_LAT+1 cycles after reset; one more lets prev catch up.
    localparam int unsigned ARM_LEN = SYNC_STAGES + DEB_LAT + 2;
    localparam int unsigned AW      = clog2(ARM_LEN + 1);
    localparam logic [AW-1:0] ARM_MAX = AW'(ARM_LEN);
    localparam pio_edge_e EDGE_SEL = pio_edge_e'(EDGE_TYPE[1:0]);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] wdata_w;
    logic [AW-1:0]    arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic             wr;
    logic             unused_ok;

    assign unused_ok = ^{writedata, DEBOUNCE_CYCLES};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    for (genvar b = 0; b < int'(WIDTH); b++) begin : g_deb
        platform_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i      (clk),
            .rst_i      (reset),
            .sync_i     (sync_w[b]),
            .filtered_o (filtered[b])
        );
    end
`else
    logic [WIDTH-1:0] filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) filt_q <= '0;
        else       filt_q <= sync_w;
    end

    assign filtered = filt_q;
`endif

    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (arm_cnt_q != ARM_MAX) arm_cnt_d = arm_cnt_q + 1'b1;
    end

    assign armed   = (arm_cnt_q == ARM_MAX);
    assign wr      = chipselect & ~write_n;
    assign wdata_w = writedata[WIDTH-1:0];

    always_comb begin
        case (EDGE_SEL)
            PIO_EDGE_FALL: edge_w = ~filtered & prev_q;
            PIO_EDGE_ANY:  edge_w = filtered ^ prev_q;
            default:       edge_w = filtered & ~prev_q;
        endcase
    end

    always_comb begin
        ecap_d = ecap_q;
        mask_d = mask_q;
        if (wr && address == PIO_ADDR_EDGECAP) ecap_d = ecap_d & ~wdata_w;
        if (wr && address == PIO_ADDR_IRQMASK) mask_d = wdata_w;
        // Capture is applied after the clear so a colliding edge keeps its bit.
        if (armed) ecap_d = ecap_d | edge_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            mask_q    <= '0;
            ecap_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            prev_q    <= filtered;
            mask_q    <= mask_d;
            ecap_q    <= ecap_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA:    readdata[WIDTH-1:0] = filtered;
            PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = mask_q;
            PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = ecap_q;
            default:          readdata = '0;
        endcase
    end

    assign irq = |(ecap_q & mask_q);

endmodule

// File: tb/tb_platform_pio_keys_in.sv
// Scoreboard bench for platform_pio_keys_in: driver pushes model-predicted read results,
// a negedge monitor pops and compares them against the DUT.
module tb_platform_pio_keys_in;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int ET = 0;
    localparam int D  = 8;
`ifdef PIO_DEBOUNCE_EN
    localparam int DEB = D;
`else
    localparam int DEB = 0;
`endif
    localparam int LAT = S + 1 + DEB;   // in_port sample edge -> DATA visible
    localparam int ARM = LAT + 1;       // edges counted from reset release before capture allowed

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = 4'hF;
    logic [31:0]  readdata;
    logic         irq;

    platform_pio_keys_in #(
        .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: register contents after the most recent clock edge.
    logic [W-1:0] m_filt, m_prev, m_ec, m_mask, m_last;
    int           m_run [W];
    int           m_edges;
    logic [W-1:0] m_hist[$];   // in_port sampled at past edges, newest first

    task automatic model_reset();
        m_filt = '0; m_prev = '0; m_ec = '0; m_mask = '0; m_last = '0;
        for (int b = 0; b < W; b++) m_run[b] = 1;
        m_edges = 0;
        m_hist.delete();
    endtask

    task automatic model_edge(input logic [W-1:0] in_v, input logic wr,
                              input logic [1:0] a, input logic [31:0] wd);
        logic [W-1:0] s, nf, ev;
        m_edges++;
        s = (m_hist.size() >= S) ? m_hist[S-1] : '0;
        if (DEB == 0) begin
            nf = s;
        end else begin
            nf = m_filt;
            for (int b = 0; b < W; b++) begin
                m_run[b] = (s[b] == m_last[b]) ? m_run[b] + 1 : 1;
                m_last[b] = s[b];
                if (m_run[b] >= DEB + 1) nf[b] = s[b];
            end
        end
        case (ET)
            1:       ev = ~m_filt & m_prev;
            2:       ev = m_filt ^ m_prev;
            default: ev = m_filt & ~m_prev;
        endcase
        if (wr && a == 2'd3) m_ec = m_ec & ~wd[W-1:0];
        if (m_edges >= ARM + 1) m_ec = m_ec | ev;
        if (wr && a == 2'd2) m_mask = wd[W-1:0];
        m_prev = m_filt;
        m_filt = nf;
        m_hist.push_front(in_v);
        if (m_hist.size() > S + 2) void'(m_hist.pop_back());
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_filt};
            2'd2:    return {28'd0, m_mask};
            2'd3:    return {28'd0, m_ec};
            default: return 32'd0;
        endcase
    endfunction

    // Called #1 after a posedge; drives one bus cycle and advances to #1 after the next posedge.
    task automatic cycle(input logic [W-1:0] in_v, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
        exp_t e;
        in_port = in_v; chipselect = cs; write_n = wn; address = a; writedata = wd;
        if (cs && wn) begin
            e.addr = a;
            e.rd   = model_read(a);
            e.irq  = |(m_ec & m_mask);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (!reset) model_edge(in_v, cs & ~wn, a, wd);
        #1;
    endtask

    task automatic rd(input logic [W-1:0] in_v, input logic [1:0] a);
        cycle(in_v, 1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic wr(input logic [W-1:0] in_v, input logic [1:0] a, input logic [31:0] wd);
        cycle(in_v, 1'b1, 1'b0, a, wd);
    endtask

    task automatic hold(input logic [W-1:0] in_v, input int n);
        for (int i = 0; i < n; i++) rd(in_v, 2'(i % 4));
    endtask

    task automatic apply_reset(input logic [W-1:0] in_v);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) rd(in_v, 2'(i));
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (readdata !== e.rd || irq !== e.irq) begin
                n_bad++;
                $display("FAIL read_addr%0d @%0t: got rd=%h irq=%b, want rd=%h irq=%b",
                         e.addr, $time, readdata, irq, e.rd, e.irq);
            end
        end
    end

    initial begin
        logic [W-1:0] cur;
        int           hold_left;
        int           op;

        @(posedge clk); #1;
        // Idle-high keys across reset: no spurious capture once armed.
        apply_reset(4'hF);
        hold(4'hF, ARM + 6);

        // Rising edge on bit0 with mask 0x1, then W1C clear.
        wr(4'hF, 2'd2, 32'h1);
        hold(4'hE, LAT + 3);
        hold(4'hF, LAT + 3);
        wr(4'hF, 2'd3, 32'h1);
        hold(4'hF, 4);

        // W1C of bit2 on the very edge that captures a new bit2 rise.
        hold(4'hB, LAT + 3);
        wr(4'hB, 2'd3, 32'hF);
        rd(4'hF, 2'd3);
        for (int i = 0; i < LAT - 1; i++) rd(4'hF, 2'd3);
        wr(4'hF, 2'd3, 32'h4);
        hold(4'hF, 4);

        // Short and long pulses on bit1 (from low).
        wr(4'hF, 2'd3, 32'hF);
        hold(4'hD, LAT + 3);
        wr(4'hD, 2'd3, 32'hF);
        for (int i = 0; i < 5; i++) rd(4'hF, 2'(i % 4));
        hold(4'hD, LAT + 4);
        for (int i = 0; i < 20; i++) rd(4'hF, 2'(i % 4));
        hold(4'hF, LAT + 4);

        // Address 1 reads zero, writes to 0/1 ignored, mask enable/disable of irq.
        wr(4'hF, 2'd0, 32'h0);
        wr(4'hF, 2'd1, 32'hFFFF_FFFF);
        rd(4'hF, 2'd1);
        rd(4'hF, 2'd0);
        wr(4'hF, 2'd2, 32'hFFFF_FFF0);
        rd(4'hF, 2'd2);
        wr(4'hF, 2'd2, 32'h2);
        rd(4'hF, 2'd3);

        // Randomised traffic.
        cur = 4'hF;
        hold_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_left == 0) begin
                cur = 4'($urandom);
                hold_left = (DEB != 0) ? $urandom_range(2, 3 * D) : $urandom_range(1, 6);
            end
            hold_left--;
            op = $urandom_range(0, 9);
            if (op < 6)      rd(cur, 2'($urandom));
            else if (op < 9) wr(cur, 2'($urandom), $urandom);
            else             cycle(cur, 1'b0, 1'($urandom), 2'($urandom), $urandom);
        end

        // Reset mid-capture, then edges inside the arm window.
        wr(4'h0, 2'd2, 32'hF);
        hold(4'h0, LAT + 3);
        wr(4'h0, 2'd3, 32'hF);
        hold(4'h5, LAT + 3);
        rd(4'h5, 2'd3);
        apply_reset(4'h0);
        rd(4'hF, 2'd3);
        hold(4'hF, LAT + 6);
        wr(4'hF, 2'd2, 32'hF);
        rd(4'hF, 2'd3);

        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
